// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: classifies each retiring instruction, stamps it with
// instruction/cycle numbers and queues it for a valid/ready reader. Macro: TRACE_FILTER_EN.
module retire_trace_buffer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ev_valid,
    input  logic                    ev_halt,
    input  logic                    ev_regwrite,
    input  logic                    ev_memwrite,
    input  logic                    ev_memread,
    input  logic [ADDR_W-1:0]       ev_pc,
    input  logic [REG_W-1:0]        ev_reg,
    input  logic [DATA_W-1:0]       ev_wdata,
    input  logic [ADDR_W-1:0]       ev_addr,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [1:0]              rd_kind,
    output logic                    rd_ld,
    output logic [CNT_W-1:0]        rd_inum,
    output logic [CNT_W-1:0]        rd_cycle,
    output logic [ADDR_W-1:0]       rd_pc,
    output logic [REG_W-1:0]        rd_reg,
    output logic [DATA_W-1:0]       rd_data,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    halted,
    output logic                    timeout,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int REC_W = 3 + 2 * CNT_W + 2 * ADDR_W + REG_W + DATA_W;
    localparam logic [PTR_W:0]   FULL_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ZERO_C = {(PTR_W + 1){1'b0}};
    localparam logic [CNT_W-1:0] MAXC_C = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] ONES_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PONE_C = PTR_W'(1);

    logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             halted_q, halted_d, timeout_q, timeout_d, overflow_q, overflow_d;
    logic [REC_W-1:0] mem_q [DEPTH];

    logic [1:0]       kind_s;
    logic             accept_s, store_s, pop_s, full_s, push_s, drop_s;
    logic [REC_W-1:0] rec_s, head_s;

    // Priority classification: halt > regwrite > memwrite > other.
    always_comb begin
        kind_s = 2'd0;
        if (ev_halt) begin
            kind_s = 2'd3;
        end else if (ev_regwrite) begin
            kind_s = 2'd1;
        end else if (ev_memwrite) begin
            kind_s = 2'd2;
        end else begin
            kind_s = 2'd0;
        end
    end

    // Accept/store/pop decisions; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        accept_s = ev_valid & ~halted_q & ~timeout_q;
`ifdef TRACE_FILTER_EN
        store_s  = accept_s & (kind_s != 2'd0);
`else
        store_s  = accept_s;
`endif
        full_s   = (count_q == FULL_C);
        pop_s    = (count_q != ZERO_C) & rd_ready;
        push_s   = store_s & (~full_s | pop_s);
        drop_s   = store_s & full_s & ~pop_s;
    end

    assign rec_s = {kind_s, ev_regwrite & ev_memread, inst_q, cycle_q,
                    ev_pc, ev_reg, ev_wdata, ev_addr};

    // Next-state for counters, pointers and sticky flags.
    always_comb begin
        cycle_d    = (cycle_q == ONES_C) ? cycle_q : cycle_q + ONE_C;
        inst_d     = accept_s ? inst_q + ONE_C : inst_q;
        drop_d     = (drop_s && (drop_q != ONES_C)) ? drop_q + ONE_C : drop_q;
        wr_ptr_d   = push_s ? wr_ptr_q + PONE_C : wr_ptr_q;
        rd_ptr_d   = pop_s ? rd_ptr_q + PONE_C : rd_ptr_q;
        count_d    = count_q + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(pop_s);
        halted_d   = halted_q | (accept_s & ev_halt);
        timeout_d  = timeout_q | (cycle_d >= MAXC_C);
        overflow_d = overflow_q | drop_s;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q    <= {CNT_W{1'b0}};
            inst_q     <= {CNT_W{1'b0}};
            drop_q     <= {CNT_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= ZERO_C;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            inst_q     <= inst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage; stale contents are masked on the read side when empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rec_s;
        end
    end

    assign head_s   = (count_q != ZERO_C) ? mem_q[rd_ptr_q] : {REC_W{1'b0}};
    assign {rd_kind, rd_ld, rd_inum, rd_cycle, rd_pc, rd_reg, rd_data, rd_addr} = head_s;
    assign rd_valid = (count_q != ZERO_C);
    assign count    = count_q;
    assign halted   = halted_q;
    assign timeout  = timeout_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomised and directed bench for retire_trace_buffer against a queue-based model.
module tb_retire_trace_buffer;
    localparam int DEPTH  = 16;
    localparam int TB_MAX = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_valid = 1'b0, ev_halt = 1'b0, ev_regwrite = 1'b0;
    logic        ev_memwrite = 1'b0, ev_memread = 1'b0;
    logic [15:0] ev_pc = 16'h0, ev_wdata = 16'h0, ev_addr = 16'h0;
    logic [3:0]  ev_reg = 4'h0;
    logic        rd_ready = 1'b0;
    logic        rd_valid, rd_ld, halted, timeout, overflow;
    logic [1:0]  rd_kind;
    logic [31:0] rd_inum, rd_cycle, drop_cnt;
    logic [15:0] rd_pc, rd_data, rd_addr;
    logic [3:0]  rd_reg;
    logic [4:0]  count;

    retire_trace_buffer #(.DEPTH(DEPTH), .MAX_CYCLES(TB_MAX)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_halt(ev_halt),
        .ev_regwrite(ev_regwrite), .ev_memwrite(ev_memwrite), .ev_memread(ev_memread),
        .ev_pc(ev_pc), .ev_reg(ev_reg), .ev_wdata(ev_wdata), .ev_addr(ev_addr),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_kind(rd_kind), .rd_ld(rd_ld),
        .rd_inum(rd_inum), .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_reg(rd_reg),
        .rd_data(rd_data), .rd_addr(rd_addr), .count(count), .halted(halted),
        .timeout(timeout), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic        ld;
        logic [31:0] inum;
        logic [31:0] cyc;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] data;
        logic [15:0] addr;
    } rec_t;

    rec_t        mq[$];
    int unsigned m_inum, m_cycle, m_drop;
    bit          m_halted, m_timeout, m_over;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step of the trace unit per rising edge.
    task automatic model_step();
        rec_t r;
        bit   pop, store;
        if (rst) begin
            mq.delete();
            m_inum = 0; m_cycle = 0; m_drop = 0;
            m_halted = 0; m_timeout = 0; m_over = 0;
            return;
        end
        pop = (mq.size() > 0) && rd_ready;
        if (pop) void'(mq.pop_front());
        if (ev_valid && !m_halted && !m_timeout) begin
            r.kind = ev_halt ? 2'd3 : ev_regwrite ? 2'd1 : ev_memwrite ? 2'd2 : 2'd0;
            r.ld = ev_regwrite & ev_memread;
            r.inum = m_inum; r.cyc = m_cycle;
            r.pc = ev_pc; r.rg = ev_reg; r.data = ev_wdata; r.addr = ev_addr;
`ifdef TRACE_FILTER_EN
            store = (r.kind != 2'd0);
`else
            store = 1'b1;
`endif
            if (store) begin
                if (mq.size() < DEPTH) mq.push_back(r);
                else begin
                    m_over = 1;
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                end
            end
            m_inum++;
            if (ev_halt) m_halted = 1;
        end
        if (m_cycle != 32'hFFFF_FFFF) m_cycle++;
        if (m_cycle >= TB_MAX) m_timeout = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_ev(input logic v, h, rw, mw, mr, input logic [15:0] pc,
                          input logic [3:0] rg, input logic [15:0] d, a);
        ev_valid = v; ev_halt = h; ev_regwrite = rw; ev_memwrite = mw; ev_memread = mr;
        ev_pc = pc; ev_reg = rg; ev_wdata = d; ev_addr = a;
    endtask

    task automatic idle();
        set_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        rec_t h;
        #2;
        h = '0;
        if (rst) begin
            chk("rst_valid", 64'(rd_valid), 64'd0);
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_flags", 64'({halted, timeout, overflow}), 64'd0);
            chk("rst_drop", 64'(drop_cnt), 64'd0);
            chk("rst_head", 64'({rd_kind, rd_ld, rd_inum}), 64'd0);
        end else begin
            if (mq.size() > 0) h = mq[0];
            chk("valid", 64'(rd_valid), 64'(mq.size() > 0));
            chk("count", 64'(count), 64'(mq.size()));
            chk("halted", 64'(halted), 64'(m_halted));
            chk("timeout", 64'(timeout), 64'(m_timeout));
            chk("overflow", 64'(overflow), 64'(m_over));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("kind", 64'(rd_kind), 64'(h.kind));
            chk("ld", 64'(rd_ld), 64'(h.ld));
            chk("inum", 64'(rd_inum), 64'(h.inum));
            chk("cycle", 64'(rd_cycle), 64'(h.cyc));
            chk("pc_reg", 64'({rd_pc, rd_reg}), 64'({h.pc, h.rg}));
            chk("data_addr", 64'({rd_data, rd_addr}), 64'({h.data, h.addr}));
        end
    end

    initial begin
        int len, rp;
        rd_ready = 1'b0;
        idle();
        tick();
        do_reset();

        // Single regwrite at cycle 3.
        for (int i = 0; i < 3; i++) tick();
        set_ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 4'd3, 16'h00AB, 16'h0000);
        tick();
        idle();
        chk("t1_valid", 64'(rd_valid), 64'd1);
        chk("t1_kind", 64'(rd_kind), 64'd1);
        chk("t1_inum", 64'(rd_inum), 64'd0);
        chk("t1_cycle", 64'(rd_cycle), 64'd3);
        chk("t1_count", 64'(count), 64'd1);
        chk("t1_model", 64'(mq.size()), 64'd1);

        // Load then store.
        do_reset();
        set_ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 4'd5, 16'h1234, 16'h0040);
        tick();
        set_ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 4'd0, 16'h5678, 16'h0042);
        tick();
        idle();
        chk("t2_kind0", 64'(rd_kind), 64'd1);
        chk("t2_ld0", 64'(rd_ld), 64'd1);
        chk("t2_addr0", 64'(rd_addr), 64'h40);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t2_kind1", 64'(rd_kind), 64'd2);
        chk("t2_addr1", 64'(rd_addr), 64'h42);
        chk("t2_inum1", 64'(rd_inum), 64'd1);

        // Overflow, then full push with simultaneous pop.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(i), 4'(i), 16'(i * 3), 16'h0);
            tick();
        end
        chk("t3_count", 64'(count), 64'd16);
        chk("t3_over", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        rd_ready = 1'b1;
        tick();
        idle();
        chk("t3_count_pp", 64'(count), 64'd16);
        for (int i = 0; i < 15; i++) tick();
        chk("t3_last_inum", 64'(rd_inum), 64'd18);
        tick();
        chk("t3_empty", 64'(rd_valid), 64'd0);
        rd_ready = 1'b0;

        // Halt at inum 5, later events ignored, FIFO drains.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_ev(1'b1, i == 5, 1'b1, 1'b0, 1'b0, 16'(i), 4'd1, 16'(i), 16'h0);
            tick();
        end
        idle();
        chk("t4_halted", 64'(halted), 64'd1);
        chk("t4_count", 64'(count), 64'd6);
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_hkind", 64'(rd_kind), 64'd3);
        chk("t4_hinum", 64'(rd_inum), 64'd5);
        tick();
        chk("t4_empty", 64'(rd_valid), 64'd0);
        rd_ready = 1'b0;

        // Watchdog at cycle TB_MAX, then reset clears it.
        do_reset();
        for (int i = 0; i < TB_MAX - 1; i++) tick();
        chk("t5_no_to", 64'(timeout), 64'd0);
        set_ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 4'd2, 16'h0, 16'h0);
        tick();
        chk("t5_to", 64'(timeout), 64'd1);
        chk("t5_cnt1", 64'(count), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        idle();
        chk("t5_frozen", 64'(count), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_to", 64'(timeout), 64'd0);
        chk("t5_rst_cnt", 64'(count), 64'd0);
        chk("t5_rst_drop", 64'(drop_cnt), 64'd0);
        tick();
        rst = 1'b0;

`ifdef TRACE_FILTER_EN
        // Filtering: other, reg, other, mem.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_ev(1'b1, 1'b0, i == 1, i == 3, 1'b0, 16'(i), 4'd1, 16'(i), 16'(i));
            tick();
        end
        idle();
        chk("t6_count", 64'(count), 64'd2);
        chk("t6_inum0", 64'(rd_inum), 64'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t6_inum1", 64'(rd_inum), 64'd3);
`endif

        // Random segments with resets in between and occasionally mid-segment.
        for (int s = 0; s < 150; s++) begin
            do_reset();
            rp  = $urandom_range(0, 100);
            len = $urandom_range(5, 45);
            for (int c = 0; c < len; c++) begin
                set_ev(($urandom % 4) != 0, ($urandom % 16) == 0, 1'($urandom), 1'($urandom),
                       1'($urandom), 16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
                rd_ready = ($urandom % 100) < rp;
                if (($urandom % 200) == 0) do_reset();
                else tick();
            end
        end
        idle();
        rd_ready = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
Synthesizable retirement-trace capture unit for the 16-bit CPU. It generalises the bench-side INUM/PC/REG/ADDR trace logging into hardware.
- Classifies each retired instruction as reg-write, mem-write, halt or other.
- Stamps each with an instruction number and cycle number.
- Buffers the records in a parametrised FIFO drained by a valid/ready reader (bench, UART or debug port).
- Sits beside the cpu top level and is fed by the writeback/retire stage.

Parameters:
DATA_W, 16, register and memory data width
ADDR_W, 16, PC and memory address width
REG_W, 4, register index width
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, 32, width of the cycle, instruction and drop counters
MAX_CYCLES, 100000, watchdog limit on the cycle counter

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
ev_valid  in  1  one instruction retires this cycle
ev_halt  in  1  retiring instruction is HLT
ev_regwrite  in  1  retiring instruction writes the register file
ev_memwrite  in  1  retiring instruction writes memory
ev_memread  in  1  retiring instruction reads memory
ev_pc  in  ADDR_W  PC of the retiring instruction
ev_reg  in  REG_W  destination register
ev_wdata  in  DATA_W  register write data, or memory store data
ev_addr  in  ADDR_W  memory address
rd_ready  in  1  reader accepts the head entry
rd_valid  out  1  FIFO non-empty
rd_kind  out  2  head record kind: 0 = other, 1 = reg, 2 = mem, 3 = halt
rd_ld  out  1  head record is a reg write that came from a memory load
rd_inum  out  CNT_W  instruction number of the head record
rd_cycle  out  CNT_W  cycle stamp of the head record
rd_pc  out  ADDR_W  head record PC
rd_reg  out  REG_W  head record register index
rd_data  out  DATA_W  head record data
rd_addr  out  ADDR_W  head record address
count  out  $clog2(DEPTH)+1  current occupancy
halted  out  1  sticky; capture is frozen
timeout  out  1  sticky; watchdog fired
overflow  out  1  sticky; at least one record was dropped
drop_cnt  out  CNT_W  number of dropped records, saturating

Behaviour:
- Reset (asynchronous):
  - All counters, pointers and sticky flags are cleared to 0.
  - rd_valid = 0 and count = 0.
  - rd_* fields read 0 while the FIFO is empty; this holds during and after reset.
- Cycle counter:
  - Increments on every clk edge while rst is low, including after halt.
  - Saturates at all-ones.
- Classification, in priority order: halt > regwrite > memwrite > other.
  - Applied to the ev_* flags when ev_valid = 1.
  - rd_ld = ev_regwrite & ev_memread.
- Capture:
  - An event is accepted when ev_valid = 1 and halted = 0 and timeout = 0.
  - The record holds inst_cnt before the increment (first record has inum 0) and the current cycle_cnt.
  - inst_cnt increments on every accepted event, whether stored or dropped.
- FIFO:
  - Show-ahead: rd_* present the head entry combinationally from the storage array.
  - Pop on rd_valid & rd_ready.
  - Latency: an event accepted at edge N is visible on rd_* after edge N when the FIFO was empty.
  - Full with simultaneous pop: the push succeeds and count stays at DEPTH.
  - Empty: rd_ready is ignored.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Overflow:
  - An accepted event arriving while the FIFO is full with no pop is dropped.
  - overflow is set and drop_cnt increments, saturating.
- Halt:
  - A halt record is pushed, or dropped under overflow rules.
  - halted rises at that same edge.
  - All later events are ignored: not counted, not stored.
  - The FIFO keeps draining normally.
- Watchdog:
  - When cycle_cnt reaches MAX_CYCLES, timeout is set at that edge.
  - Capture freezes exactly as for halt.
  - No record is pushed for the timeout itself.
- Reset mid-operation:
  - Discards all buffered entries and counts immediately.
  - Capture restarts with inum 0 and cycle 0.

Optional Feature:
TRACE_FILTER_EN
- Defined:
  - Events classified "other" (branch/NOP) are counted in inst_cnt but never stored.
  - They cannot cause overflow.
  - This gives an inum gap at each filtered instruction.
- Undefined: every accepted event is stored.

Test Plan:
- Reset, then one regwrite event (pc 0x0002, reg 3, data 0x00AB) at cycle 3, rd_ready = 0 → rd_valid = 1, kind 1, inum 0, cycle 3, count 1.
- Load (regwrite + memread, addr 0x0040, data 0x1234), then store (memwrite, addr 0x0042, data 0x5678) → two entries: kind 1 with rd_ld = 1 and addr 0x0040, then kind 2 with addr 0x0042; inums 0 and 1.
- DEPTH = 16, rd_ready = 0, 18 events → count 16, overflow = 1, drop_cnt 2. Next cycle, rd_ready = 1 together with an event → count stays 16 and the new entry gets inum 18.
- Halt at inum 5, then 3 further events → halt entry kind 3, halted = 1, no further pushes; the FIFO drains to empty and rd_valid = 0.
- MAX_CYCLES = 20 with no halt → timeout = 1 at cycle 20; later events are ignored. Asserting rst then clears timeout, count and drop_cnt to 0.
- With TRACE_FILTER_EN: sequence other, reg, other, mem → 2 entries stored, inums 1 and 3.
